// File: rtl/display_scan_controller.sv
// display_scan_controller: double-dabble binary-to-BCD converter feeding a
// multiplexed four-digit display scanner with leading-zero blanking.
module display_scan_controller #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [13:0] value,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  digit_en
);
    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;
    state_t      state, state_nxt;
    logic [29:0] sr, sr_nxt, adj;
    logic [3:0]  iter, iter_nxt;
    logic        ovf_cap, ovf_cap_nxt, overflow_nxt;
    logic [15:0] disp, disp_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        wrap, blank;
    logic [3:0]  nib_nxt, en_nxt;

    assign busy = state != IDLE;

    // sr holds {bcd[15:0], bin[13:0]}; correct BCD nibbles before each shift
    always_comb begin
        adj = sr;
        for (int i = 0; i < 4; i++)
            adj[14+4*i +: 4] = sr[14+4*i +: 4] >= 4'd5 ? sr[14+4*i +: 4] + 4'd3 : sr[14+4*i +: 4];
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        iter_nxt     = iter;
        ovf_cap_nxt  = ovf_cap;
        disp_nxt     = disp;
        overflow_nxt = overflow;
        case (state)
            IDLE: if (load) begin
                sr_nxt      = {16'd0, value > 14'd9999 ? 14'd9999 : value};
                ovf_cap_nxt = value > 14'd9999;
                iter_nxt    = 4'd0;
                state_nxt   = CONVERT;
            end
            CONVERT: begin
                sr_nxt    = adj << 1;
                iter_nxt  = iter + 4'd1;
                state_nxt = iter == 4'd13 ? LATCH : CONVERT;
            end
            LATCH: begin
                disp_nxt     = sr[29:14];
                overflow_nxt = ovf_cap;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are registered from next-state values so they track idx/disp exactly
    always_comb begin
        wrap    = cnt == 16'(SCAN_DIV - 1);
        cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
        idx_nxt = wrap ? idx + 2'd1 : idx;
        nib_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
        blank   = idx_nxt == 2'd3 ? disp_nxt[15:12] == 4'd0 :
                  idx_nxt == 2'd2 ? disp_nxt[15:8] == 8'd0 :
                  idx_nxt == 2'd1 ? disp_nxt[15:4] == 12'd0 : 1'b0;
        en_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            iter         <= '0;
            ovf_cap      <= 1'b0;
            overflow     <= 1'b0;
            disp         <= '0;
            cnt          <= '0;
            idx          <= '0;
            digit_nibble <= 4'h0;
            digit_en     <= 4'b1110;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            iter         <= iter_nxt;
            ovf_cap      <= ovf_cap_nxt;
            overflow     <= overflow_nxt;
            disp         <= disp_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            digit_nibble <= nib_nxt;
            digit_en     <= en_nxt;
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: randomized loads against a decimal reference model,
// with a queue of pending conversions consumed by a per-cycle output monitor.
module tb_display_scan_controller;
    localparam int SD = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic        busy, overflow;
    logic [3:0]  digit_nibble, digit_en;

    typedef struct {int disp; bit ovf;} exp_t;
    exp_t q[$];
    exp_t e_in, e_out;
    int checks = 0, failures = 0;
    int n = 0, busy_left = 0, exp_disp = 0;
    bit exp_ovf = 1'b0, prev_busy = 1'b0;

    display_scan_controller #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy), .overflow(overflow),
        .digit_nibble(digit_nibble), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: accepts a load only when no conversion is outstanding, 15 busy cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            busy_left = 0;
            q.delete();
        end else begin
            n++;
            if (busy_left > 0) busy_left--;
            else if (load) begin
                e_in.disp = value > 14'd9999 ? 9999 : int'(value);
                e_in.ovf  = value > 14'd9999;
                q.push_back(e_in);
                busy_left = 15;
            end
        end
    end

    // monitor: a falling busy means a result was latched; then check the scan every cycle
    always @(negedge clk) begin
        int idx, p;
        bit blank;
        if (!rst_n) begin
            exp_disp = 0;
            exp_ovf = 1'b0;
        end else if (prev_busy && !busy) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL latch: busy fell with no pending conversion at %0t", $time);
            end else begin
                e_out = q.pop_front();
                exp_disp = e_out.disp;
                exp_ovf = e_out.ovf;
            end
        end
        prev_busy = busy;
        idx = (n / SD) % 4;
        p = 10 ** idx;
        blank = idx > 0 && exp_disp < p;
        chk("busy", 32'(busy), 32'(busy_left > 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("digit_en", 32'(digit_en), blank ? 32'hf : 32'((~(1 << idx)) & 15));
        chk("digit_nibble", 32'(digit_nibble), 32'((exp_disp / p) % 10));
    end

    task automatic pulse(input int v, input int len = 1);
        load = 1'b1;
        value = 14'(v);
        repeat (len) @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int v, gap;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pulse(1234);
        repeat (40) @(negedge clk);
        pulse(7);
        repeat (40) @(negedge clk);
        pulse(0);
        repeat (40) @(negedge clk);
        pulse(12000);
        repeat (40) @(negedge clk);
        pulse(5);
        repeat (40) @(negedge clk);
        pulse(4321);
        repeat (4) @(negedge clk);
        pulse(1111);
        repeat (10) @(negedge clk);
        pulse(1111);
        repeat (40) @(negedge clk);
        pulse(8888);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_digit_en", 32'(digit_en), 32'b1110);
        chk("reset_nibble", 32'(digit_nibble), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        pulse(9999);
        repeat (40) @(negedge clk);
        repeat (60) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 16383);
            gap = $urandom_range(0, 25);
            repeat (gap) @(negedge clk);
            pulse(v, $urandom_range(1, 3));
        end
        repeat (40) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays active (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port load  input  1  request to convert and display value; sampled on rising edge.
REQ-005 SHALL have port value  input  14  unsigned binary number to display (e.g. multiplier product).
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress; load ignored while high.
REQ-007 SHALL have port overflow  output  1  high when the last accepted value exceeded 9999.
REQ-008 SHALL have port digit_nibble  output  4  BCD digit feeding the shared seven-segment decoder intake.
REQ-009 SHALL have port digit_en  output  4  active-low digit select, bit 0 = least significant digit.

Function
REQ-010 SHALL hold a 16-bit display register of four BCD digits; the scanner reads only this register.
REQ-011 SHALL implement FSM states IDLE, CONVERT, LATCH; reset state IDLE.
REQ-012 SHALL, in IDLE with load=1 at edge k, capture value (clamped to 9999 if >9999), set busy=1 and enter CONVERT after edge k.
REQ-013 SHALL ignore load while busy=1; no queuing, no effect on the conversion in progress.
REQ-014 SHALL in CONVERT perform one shift-add-3 (double-dabble) iteration per cycle, exactly 14 iterations at edges k+1..k+14.
REQ-015 SHALL in LATCH (edge k+15) write the BCD result to the display register, update overflow, clear busy and return to IDLE; busy is high for exactly 15 cycles.
REQ-016 SHALL set overflow=1 when captured value >9999, else 0, updated only at LATCH.
REQ-017 SHALL accept a new load at edge k+16 at the earliest (back-to-back loads allowed once busy=0).
REQ-018 SHALL run a prescaler 0..SCAN_DIV-1 continuously, independent of FSM state; on wrap, digit index advances 0->1->2->3->0.
REQ-019 SHALL with SCAN_DIV=1 advance digit index every cycle.
REQ-020 SHALL drive digit_nibble = display digit[index] and digit_en = all ones except bit[index]=0.
REQ-021 SHALL blank leading zeros: digit_en = 4'b1111 for index>0 when that digit and all more significant digits are zero; digit 0 is never blanked.
REQ-022 SHALL change the display register only at LATCH, so a partially converted value never appears on digit_nibble.
REQ-023 SHALL make digit_nibble and digit_en registered outputs (no combinational path from load/value).

Reset
REQ-024 SHALL on rst_n=0 immediately force: state IDLE, busy=0, overflow=0, display register 0, prescaler 0, index 0, digit_nibble=4'h0, digit_en=4'b1110.
REQ-025 SHALL on reset mid-conversion abort it; the display register stays 0 and the aborted value is never shown.
REQ-026 SHALL resume scanning on the first rising edge after rst_n deasserts.

Verification (SCAN_DIV=4)
REQ-027 Reset: rst_n low mid-cycle -> outputs at reset values without waiting for clk; digit_en=4'b1110, nibble 0.
REQ-028 Load 1234 at edge k -> busy high k+1..k+15; after k+15 scan yields nibbles 4,3,2,1 with digit_en 1110,1101,1011,0111, 4 cycles each.
REQ-029 Load 7 -> digits 1-3 blanked (digit_en=1111 during their slots), digit 0 shows 7; load 0 -> digit 0 shows 0.
REQ-030 Load 12000 -> overflow=1 after LATCH, display shows 9999; then load 5 -> overflow=0, display 5.
REQ-031 Load 4321 then load 1111 at k+5 -> second load ignored, display 4321; load 1111 at k+16 -> accepted, display 1111 after k+31.
REQ-032 Load 8888 then rst_n low at k+7 -> busy=0 immediately; after release display stays 0, no 8888 ever appears.
